// File: rtl/ins_loader.sv
// ---------------------------------------------------------------------------
// ins_loader : writer side of the instruction memory.
//
// Collects little-endian bytes from the host link (valid/ready), packs each
// group of NB bytes into one INS_W-bit instruction word and writes it into the
// instruction BRAM at consecutive addresses starting at 0.  Loading ends on a
// HALT opcode or when the last BRAM address has been written.  ins_valid is
// then raised so the decoder may wrap its fetch address to 0 and run.
//
// Optional feature (macro INS_LOADER_CHKSUM_EN): every instruction carries one
// extra trailing byte, the XOR of its NB data bytes.  A mismatching word is
// dropped, err is set (sticky per program) and the same address is reloaded.
// With the macro undefined, err is tied 0.
//
// Ports
//   clk, rstn        clock, synchronous active-low reset
//   s_data/s_valid   byte stream from host; s_ready = byte accepted this cycle
//   bram_ins_we      write strobe, high only in WRITE
//   bram_ins_waddr   write address (holds last value)
//   bram_ins_dout    packed instruction word (holds last value)
//   ins_valid        program loaded, decoder may run
//   load_busy        high in COLLECT or WRITE
//   ins_count        words written in the current program
//   err              sticky checksum error
// ---------------------------------------------------------------------------
module ins_loader #(
   parameter  int INS_ADDR_WIDTH = 10,
   parameter  int OPCODE_WIDTH   = 3,
   parameter  int ADDR_WIDTH     = 10,
   parameter  int IMG_SIZE_WIDTH = 5,
   localparam int INS_W          = OPCODE_WIDTH + 3*ADDR_WIDTH + IMG_SIZE_WIDTH,
   localparam int NB             = (INS_W + 7) / 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [7:0]                s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic                      bram_ins_we,
   output logic [INS_ADDR_WIDTH-1:0] bram_ins_waddr,
   output logic [INS_W-1:0]          bram_ins_dout,
   output logic                      ins_valid,
   output logic                      load_busy,
   output logic [INS_ADDR_WIDTH:0]   ins_count,
   output logic                      err
);

   // Index of the byte that completes an instruction.
`ifdef INS_LOADER_CHKSUM_EN
   localparam int LAST = NB;
`else
   localparam int LAST = NB - 1;
`endif
   localparam int CW = $clog2(LAST + 1) + 1;

   localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(3'b110);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   state_t                    r_state;
   logic [CW-1:0]             r_cnt;
   logic [INS_W-1:0]          r_buf;
   logic [INS_ADDR_WIDTH-1:0] r_addr;
   logic                      r_s_ready;
   logic                      r_we;
   logic [INS_ADDR_WIDTH-1:0] r_waddr;
   logic [INS_W-1:0]          r_dout;
   logic                      r_valid;
   logic                      r_busy;
   logic [INS_ADDR_WIDTH:0]   r_count;

   logic                      w_acc;
   logic                      w_start;
   logic [CW-1:0]             w_idx;
   logic [INS_W-1:0]          w_word;
   logic                      w_chk_ok;

   assign w_acc   = s_valid && r_s_ready;
   // A byte taken in IDLE or DONE is byte 0 of a fresh program.
   assign w_start = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_idx   = w_start ? '0 : r_cnt;

`ifdef INS_LOADER_CHKSUM_EN
   logic [7:0] r_chk;
   logic       r_err;

   // All data bytes are already buffered when the checksum byte arrives.
   always_comb begin
      w_word   = r_buf;
      w_chk_ok = (r_chk == s_data);
   end
   assign err = r_err;
`else
   // The completing byte is still on s_data; splice it into the top byte.
   always_comb begin
      w_word   = r_buf;
      w_chk_ok = 1'b1;
      for (int i = 8*(NB-1); i < INS_W; i++)
         w_word[i] = s_data[i%8];
   end
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_buf     <= '0;
         r_addr    <= '0;
         r_s_ready <= 1'b1;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_dout    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_count   <= '0;
`ifdef INS_LOADER_CHKSUM_EN
         r_chk     <= '0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_we <= 1'b0;

         // Byte store; bits past INS_W-1 of the top byte have no home and drop.
         if (w_acc) begin
            for (int i = 0; i < INS_W; i++)
               if (i/8 == int'(w_idx)) r_buf[i] <= s_data[i%8];
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_acc) begin
                  r_cnt   <= CW'(1);
                  r_addr  <= '0;
                  r_count <= '0;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_COLLECT;
`ifdef INS_LOADER_CHKSUM_EN
                  r_chk   <= s_data;
                  r_err   <= 1'b0;
`endif
               end
            end

            S_COLLECT: begin
               if (w_acc) begin
                  if (r_cnt == CW'(LAST)) begin
                     r_cnt <= '0;
                     if (w_chk_ok) begin
                        r_we      <= 1'b1;
                        r_waddr   <= r_addr;
                        r_dout    <= w_word;
                        r_s_ready <= 1'b0;
                        r_state   <= S_WRITE;
                     end
`ifdef INS_LOADER_CHKSUM_EN
                     else begin
                        // Bad word: drop it and reload the same address.
                        r_err <= 1'b1;
                     end
`endif
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
`ifdef INS_LOADER_CHKSUM_EN
                     r_chk <= (r_cnt == '0) ? s_data : (r_chk ^ s_data);
`endif
                  end
               end
            end

            S_WRITE: begin
               r_count   <= r_count + 1'b1;
               r_s_ready <= 1'b1;
               // The top address ends the program so waddr never wraps.
               if (r_dout[OPCODE_WIDTH-1:0] == OP_HALT || &r_addr) begin
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_addr  <= r_addr + 1'b1;
                  r_state <= S_COLLECT;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_ready        = r_s_ready;
   assign bram_ins_we    = r_we;
   assign bram_ins_waddr = r_waddr;
   assign bram_ins_dout  = r_dout;
   assign ins_valid      = r_valid;
   assign load_busy      = r_busy;
   assign ins_count      = r_count;

endmodule

// File: tb/tb_ins_loader.sv
// ---------------------------------------------------------------------------
// tb_ins_loader : scoreboard bench for ins_loader (default parameters).
// Expected BRAM writes are queued as instructions are driven and compared
// when bram_ins_we is observed.  Follows INS_LOADER_CHKSUM_EN if defined.
// ---------------------------------------------------------------------------
module tb_ins_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        bram_ins_we;
   logic [9:0]  bram_ins_waddr;
   logic [37:0] bram_ins_dout;
   logic        ins_valid;
   logic        load_busy;
   logic [10:0] ins_count;
   logic        err;

   int total = 0;
   int bad   = 0;
   int nwr   = 0;

   logic [9:0]  q_addr[$];
   logic [37:0] q_data[$];
   logic [9:0]  exp_addr;

   ins_loader dut (
      .clk(clk), .rstn(rstn),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .bram_ins_we(bram_ins_we), .bram_ins_waddr(bram_ins_waddr),
      .bram_ins_dout(bram_ins_dout), .ins_valid(ins_valid),
      .load_busy(load_busy), .ins_count(ins_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Write monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (rstn === 1'b1 && bram_ins_we === 1'b1) begin
         nwr++;
         chk("rdy_in_wr", 64'(s_ready), 64'd0);
         if (q_addr.size() == 0) begin
            chk("unexp_wr", 64'(bram_ins_waddr), 64'h3ff_dead);
         end else begin
            chk("wr_addr", 64'(bram_ins_waddr), 64'(q_addr.pop_front()));
            chk("wr_data", 64'(bram_ins_dout), 64'(q_data.pop_front()));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting posedge
   // with s_valid still high.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) chk("rdy_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   // Sends 5 little-endian bytes (plus checksum when enabled).
   task automatic send_raw(input logic [39:0] v, input logic [7:0] cks);
      for (int k = 0; k < 5; k++) send_byte(v[8*k +: 8]);
`ifdef INS_LOADER_CHKSUM_EN
      send_byte(cks);
`else
      if (cks == 8'hxx) s_data = 8'h00;
`endif
   endtask

   task automatic send_ins(input logic [39:0] v, input logic [37:0] expw);
      logic [7:0] x = 8'h00;
      for (int k = 0; k < 5; k++) x ^= v[8*k +: 8];
      q_addr.push_back(exp_addr);
      q_data.push_back(expw);
      exp_addr = exp_addr + 10'd1;
      send_raw(v, x);
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      s_data   = 8'h00;
      s_valid  = 1'b0;
      exp_addr = '0;
      @(negedge clk);
      do_reset();

      // Reset state
      chk("rst_ready", 64'(s_ready), 64'd1);
      chk("rst_we",    64'(bram_ins_we), 64'd0);
      chk("rst_valid", 64'(ins_valid), 64'd0);
      chk("rst_count", 64'(ins_count), 64'd0);
      chk("rst_busy",  64'(load_busy), 64'd0);
      chk("rst_err",   64'(err), 64'd0);

      // CONV_3 first instruction, then HALT
      exp_addr = '0;
      send_ins(40'h10_20_04_00_82, 38'h1020040082);
      send_ins(40'h00_00_00_00_06, 38'h6);
      s_valid = 1'b0;
      chk("halt_valid_n1", 64'(ins_valid), 64'd0);
      chk("halt_busy_n1",  64'(load_busy), 64'd1);
      @(negedge clk);
      chk("halt_valid_n2", 64'(ins_valid), 64'd1);
      chk("halt_busy_n2",  64'(load_busy), 64'd0);
      chk("halt_count",    64'(ins_count), 64'd2);
      chk("halt_q_empty",  64'(q_addr.size()), 64'd0);
      repeat (3) @(negedge clk);
      chk("done_hold",     64'(ins_valid), 64'd1);

      // Restart from DONE
      exp_addr = '0;
      q_addr.push_back(exp_addr);
      q_data.push_back(38'h6);
      exp_addr = exp_addr + 10'd1;
      send_byte(8'h06);
      s_valid = 1'b0;
      chk("restart_valid", 64'(ins_valid), 64'd0);
      chk("restart_count", 64'(ins_count), 64'd0);
      begin
         logic [39:0] v = 40'h00_00_00_00_06;
         for (int k = 1; k < 5; k++) send_byte(v[8*k +: 8]);
`ifdef INS_LOADER_CHKSUM_EN
         send_byte(8'h06);
`endif
      end
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("restart_done",  64'(ins_valid), 64'd1);
      chk("restart_cnt1",  64'(ins_count), 64'd1);

      // Back-to-back stream with s_valid held high; top byte bits truncated
      exp_addr = '0;
      send_ins(40'h78_56_34_12_81, 38'h3856341281);
      send_ins(40'h3C_C3_5A_A5_4F, 38'h3CC35AA54F);
      send_ins(40'hFF_FF_FF_FF_0E, 38'h3FFFFFFF0E);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("b2b_valid", 64'(ins_valid), 64'd1);
      chk("b2b_count", 64'(ins_count), 64'd3);
      chk("b2b_q",     64'(q_addr.size()), 64'd0);

`ifdef INS_LOADER_CHKSUM_EN
      // Bad checksum: no write, err sticky, same address retried
      send_raw(40'h00_00_00_00_06, 8'h07);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("cks_err",   64'(err), 64'd1);
      chk("cks_count", 64'(ins_count), 64'd0);
      chk("cks_busy",  64'(load_busy), 64'd1);
      exp_addr = '0;
      send_ins(40'h00_00_00_00_06, 38'h6);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("cks_ok_valid", 64'(ins_valid), 64'd1);
      chk("cks_ok_count", 64'(ins_count), 64'd1);
      chk("cks_err_stk",  64'(err), 64'd1);
`endif

      // Reset mid-instruction discards the partial word
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      do_reset();
      repeat (3) @(negedge clk);
      chk("midrst_count", 64'(ins_count), 64'd0);
      chk("midrst_busy",  64'(load_busy), 64'd0);
      chk("midrst_err",   64'(err), 64'd0);
      exp_addr = '0;
      send_ins(40'h00_00_00_00_01, 38'h1);
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_cnt1",  64'(ins_count), 64'd1);
      chk("midrst_vld",   64'(ins_valid), 64'd0);

      // Fill the whole BRAM with NOPs; the top address ends the program
      do_reset();
      exp_addr = '0;
      nwr = 0;
      for (int n = 0; n < 1024; n++) send_ins(40'h0, 38'h0);
      s_valid = 1'b0;
      chk("full_valid_n1", 64'(ins_valid), 64'd0);
      @(negedge clk);
      chk("full_valid", 64'(ins_valid), 64'd1);
      chk("full_count", 64'(ins_count), 64'd1024);
      chk("full_waddr", 64'(bram_ins_waddr), 64'd1023);
      repeat (5) @(negedge clk);
      chk("full_nwr",   64'(nwr), 64'd1024);
      chk("full_q",     64'(q_addr.size()), 64'd0);
      chk("full_busy",  64'(load_busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
